// File: rtl/fixed_to_signmag_stage.sv
// Splits two's-complement fixed-point samples into sign, integer magnitude and
// fraction magnitude, buffered in a 2-entry skid buffer with a registered s_ready.
module fixed_to_signmag_stage #(
  parameter int int_len = 16,
  parameter int fra_len = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [int_len+fra_len-1:0] s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [int_len-1:0]         m_integer,
  output logic [fra_len-1:0]         m_fraction,
  output logic                       m_sign,
  output logic                       m_zero,
  output logic [15:0]                sample_cnt
);

  localparam int N = int_len + fra_len;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic               sign;
    logic               zero;
    logic [int_len-1:0] ipart;
    logic [fra_len-1:0] fpart;
  } entry_t;

  // The most-negative input negates to itself, which read as unsigned is 2^(N-1).
  function automatic entry_t convert(input logic [N-1:0] d);
    logic [N-1:0] mag;
    entry_t       e;
    mag     = d[N-1] ? (~d + {{(N-1){1'b0}}, 1'b1}) : d;
    e.sign  = d[N-1];
    e.zero  = (mag == {N{1'b0}});
    e.ipart = mag[N-1:fra_len];
    e.fpart = mag[fra_len-1:0];
    return e;
  endfunction

  state_e      state_q, state_d;
  entry_t      head_q, head_d;
  entry_t      skid_q, skid_d;
  logic [15:0] cnt_q, cnt_d;
  logic        s_ready_q, s_ready_d;
  logic        m_valid_q, m_valid_d;
  logic        accept;
  logic        pop;
  entry_t      conv;

  assign accept = s_valid & s_ready_q;
  assign pop    = m_valid_q & m_ready;
  assign conv   = convert(s_data);

  // Next-state, buffer contents and accept counter.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q;
    if (clr) begin
      state_d = EMPTY;
      head_d  = '0;
      skid_d  = '0;
    end else begin
      if (accept) begin
        cnt_d = cnt_q + 16'd1;
      end else begin
        cnt_d = cnt_q;
      end
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            head_d  = conv;
          end else begin
            state_d = EMPTY;
          end
        end
        ONE: begin
          if (accept && !pop) begin
            state_d = FULL;
            skid_d  = conv;
          end else if (pop && !accept) begin
            state_d = EMPTY;
            head_d  = '0;
          end else if (accept && pop) begin
            head_d  = conv;
          end else begin
            state_d = ONE;
          end
        end
        FULL: begin
          if (pop) begin
            state_d = ONE;
            head_d  = skid_q;
            skid_d  = '0;
          end else begin
            state_d = FULL;
          end
        end
        default: begin
          state_d = EMPTY;
          head_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
    m_valid_d = (state_d != EMPTY);
    s_ready_d = (state_d != FULL);
  end

  // State and data registers; s_ready stays low until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      head_q    <= '0;
      skid_q    <= '0;
      cnt_q     <= 16'd0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      skid_q    <= skid_d;
      cnt_q     <= cnt_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign m_valid    = m_valid_q;
  assign m_sign     = head_q.sign;
  assign m_zero     = head_q.zero;
  assign m_integer  = head_q.ipart;
  assign m_fraction = head_q.fpart;
  assign sample_cnt = cnt_q;

endmodule

// File: doc/fixed_to_signmag_stage.md
Name: fixed_to_signmag_stage

Overview:
- Upstream feeder for the fixed-point-to-IEEE-754 converter.
- Accepts signed two's-complement fixed-point samples over a valid/ready stream.
- Splits each sample into sign flag, unsigned integer magnitude and unsigned fraction magnitude, which are the exact operand set the converter consumes.
- Registers the results in a 2-entry skid buffer so converter-side backpressure never forms a combinational ready path back to the source.

Parameters:
int_len, 16, integer field width (bits), includes the sign position of the input word
fra_len, 16, fraction field width (bits)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous flush, highest priority after reset
s_valid  input  1  input sample valid
s_ready  output  1  stage can accept input; registered
s_data  input  int_len+fra_len  two's-complement fixed-point sample, binary point between bit fra_len and bit fra_len-1
m_valid  output  1  output entry valid
m_ready  input  1  downstream (converter side) accepts
m_integer  output  int_len  unsigned integer part of |s_data|
m_fraction  output  fra_len  unsigned fraction part of |s_data|
m_sign  output  1  sign of sample (1 = negative)
m_zero  output  1  sample magnitude is zero
sample_cnt  output  16  count of samples accepted, wraps modulo 2^16

Behaviour:
- Let N = int_len+fra_len.
- Accept occurs when s_valid & s_ready at a rising edge.
- Pop occurs when m_valid & m_ready at a rising edge.
- Conversion at accept:
  - sign = s_data[N-1].
  - mag = sign ? (~s_data + 1) : s_data, as N-bit unsigned.
  - integer = mag[N-1:fra_len], fraction = mag[fra_len-1:0], zero = (mag == 0).
  - Most-negative input -2^(int_len-1) yields mag = 2^(N-1): integer = 1<<(int_len-1), fraction = 0, sign = 1. No saturation is applied.
- Storage: head entry drives the m_* outputs; a skid entry holds one more result.
- State machine:
  - EMPTY: m_valid=0, s_ready=1.
  - ONE: m_valid=1, s_ready=1.
  - FULL: m_valid=1, s_ready=0.
- Transitions:
  - EMPTY + accept -> ONE; the new result loads the head.
  - ONE + accept & !pop -> FULL; the new result loads the skid.
  - ONE + pop & !accept -> EMPTY.
  - ONE + accept & pop -> ONE; the new result replaces the head.
  - FULL + pop -> ONE; skid moves to head. No accept is possible in FULL.
  - Otherwise hold.
- Latency: 1 cycle. A result accepted at edge t is on the m_* outputs with m_valid=1 after edge t, when the buffer was EMPTY, or when it was ONE with a simultaneous pop.
- Throughput: 1 sample/cycle while m_ready is held high.
- s_ready is a flop output, updated from the next state. It never depends combinationally on m_ready.
- While m_valid=1 and m_ready=0, m_integer, m_fraction, m_sign and m_zero are held stable.
- m_zero is valid only when m_valid=1. When m_valid=0, the m_* data outputs are 0.
- sample_cnt increments by 1 per accept and wraps from 16'hFFFF to 0. clr does not reset it.
- clr=1 at an edge:
  - state -> EMPTY, head and skid data -> 0.
  - An accept in the same cycle is discarded and not counted.
  - A pop in the same cycle completes normally from the consumer's side.
- Reset (rst_n=0, asynchronous, any time including mid-transfer):
  - state = EMPTY, s_ready = 0, m_valid = 0.
  - All m_* data = 0, sample_cnt = 0.
  - s_ready rises at the first rising edge after rst_n deasserts.
- With s_valid=0 and m_ready=0, the state never changes.

Test Plan:
- int_len=16, fra_len=16, m_ready=1. Send s_data=32'hFFFF_8000 (-0.5) -> one cycle later m_valid=1, m_sign=1, m_integer=16'h0000, m_fraction=16'h8000, m_zero=0, sample_cnt=1.
- Send 32'h8000_0000, 32'h0000_0000, 32'h0003_4000 back-to-back -> consecutive outputs:
  - sign 1, integer 16'h8000, fraction 0.
  - sign 0, integer 0, fraction 0, m_zero=1.
  - sign 0, integer 3, fraction 16'h4000.
  - Throughput is 1 per cycle.
- Hold m_ready=0 and stream 4 samples -> s_ready drops after 2 accepts (FULL), the outputs stay on sample 1, sample_cnt=2. Raise m_ready -> samples 1..4 emerge in order with none lost or duplicated.
- With the buffer in FULL, pulse clr with s_valid=1 -> next cycle m_valid=0, s_ready=1, sample_cnt unchanged, the clr-cycle sample never appears.
- Assert rst_n=0 mid-stream with the buffer ONE -> m_valid, s_ready and sample_cnt go to 0 immediately without a clock edge. s_ready returns to 1 one edge after release.
- Accept 65537 samples -> sample_cnt reads 1 after wrap.
